// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI slave link.
package qspi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_READ
  } state_e;

  localparam int unsigned CMD_READ_BIT     = 7;
  localparam int unsigned NIBBLES_PER_BYTE = 2;
  localparam int unsigned NIB_W            = 4;
  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned NIB_CNT_W        = $clog2(NIBBLES_PER_BYTE);

  function automatic logic [BYTE_W-1:0] join_nibbles(input logic [NIB_W-1:0] hi,
                                                     input logic [NIB_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/qspi_rx_fifo.sv
// First-word-fall-through receive FIFO; a pop in the same cycle frees room for a push when full.
module qspi_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full_c,
  output logic             empty_c,
  output logic [WIDTH-1:0] head_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push_c, do_pop_c;

  // Extra pointer bit tells full from empty when the indices match.
  assign empty_c   = (wr_ptr_q == rd_ptr_q);
  assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop_c  = pop & ~empty_c;
  assign do_push_c = push & (~full_c | do_pop_c);
  assign head_c    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + PW'(do_push_c);
    rd_ptr_d = rd_ptr_q + PW'(do_pop_c);
    if (do_push_c) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/qspi_slave_link.sv
// QSPI slave oversampled in io_mainClk: command decode, write bytes into an RX FIFO,
// read bytes from a TX stream serialised onto QD.
module qspi_slave_link
  import qspi_pkg::*;
#(
  parameter int unsigned       RX_DEPTH  = 4,
  parameter logic [BYTE_W-1:0] FILL_BYTE = 8'hFF
) (
  input  logic              io_mainClk,
  input  logic              io_asyncReset,
  input  logic              io_qss,
  input  logic              io_qck,
  input  logic [NIB_W-1:0]  io_qd_read,
  output logic [NIB_W-1:0]  io_qd_write,
  output logic [NIB_W-1:0]  io_qd_writeEnable,
  output logic              io_cmd_valid,
  output logic [BYTE_W-1:0] io_cmd,
  output logic              io_rx_valid,
  input  logic              io_rx_ready,
  output logic [BYTE_W-1:0] io_rx_payload,
  input  logic              io_tx_valid,
  output logic              io_tx_ready,
  input  logic [BYTE_W-1:0] io_tx_payload,
  input  logic              io_clear,
  output logic              io_overrun,
  output logic              io_underrun
);

  logic [2:0]           qss_sync_q, qss_sync_d;
  logic [2:0]           qck_sync_q, qck_sync_d;
  logic [NIB_W-1:0]     qd_s1_q, qd_s1_d, qd_s2_q, qd_s2_d;
  state_e               state_q, state_d;
  logic [NIB_CNT_W-1:0] nib_cnt_q, nib_cnt_d;
  logic [NIB_W-1:0]     shift_q, shift_d;
  logic [BYTE_W-1:0]    cmd_q, cmd_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic                 oe_q, oe_d;
  logic [NIB_W-1:0]     qd_out_q, qd_out_d;
  logic [NIB_W-1:0]     rd_lo_q, rd_lo_d;
  logic                 rd_nib_q, rd_nib_d;
  logic                 overrun_q, overrun_d;
  logic                 underrun_q, underrun_d;

  logic                 qck_rise_c, qck_fall_c, qss_rise_c, qss_fall_c;
  logic                 byte_done_c, rx_push_c, tx_ready_c;
  logic                 overrun_set_c, underrun_set_c;
  logic [BYTE_W-1:0]    rx_byte_c, load_byte_c;
  logic                 fifo_full_c, fifo_empty_c;
  logic [BYTE_W-1:0]    fifo_head_c;

  // Edge strobes compare the second and third synchroniser stages.
  assign qck_rise_c  = qck_sync_q[1] & ~qck_sync_q[2];
  assign qck_fall_c  = ~qck_sync_q[1] & qck_sync_q[2];
  assign qss_rise_c  = qss_sync_q[1] & ~qss_sync_q[2];
  assign qss_fall_c  = ~qss_sync_q[1] & qss_sync_q[2];
  assign rx_byte_c   = join_nibbles(shift_q, qd_s2_q);
  assign byte_done_c = qck_rise_c && (nib_cnt_q == NIB_CNT_W'(NIBBLES_PER_BYTE - 1));

  always_comb begin
    qss_sync_d     = {qss_sync_q[1:0], io_qss};
    qck_sync_d     = {qck_sync_q[1:0], io_qck};
    qd_s1_d        = io_qd_read;
    qd_s2_d        = qd_s1_q;
    state_d        = state_q;
    nib_cnt_d      = nib_cnt_q;
    shift_d        = shift_q;
    cmd_d          = cmd_q;
    cmd_valid_d    = 1'b0;
    oe_d           = oe_q;
    qd_out_d       = qd_out_q;
    rd_lo_d        = rd_lo_q;
    rd_nib_d       = rd_nib_q;
    rx_push_c      = 1'b0;
    tx_ready_c     = 1'b0;
    underrun_set_c = 1'b0;
    load_byte_c    = FILL_BYTE;

    // Deselect overrides everything and drops any partial byte.
    if (qss_rise_c) begin
      state_d   = ST_IDLE;
      nib_cnt_d = '0;
      oe_d      = 1'b0;
      qd_out_d  = '0;
      rd_nib_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (qss_fall_c) begin
            state_d   = ST_CMD;
            nib_cnt_d = '0;
          end
        end
        ST_CMD, ST_WRITE: begin
          if (qck_rise_c) begin
            shift_d   = qd_s2_q;
            nib_cnt_d = byte_done_c ? '0 : nib_cnt_q + NIB_CNT_W'(1);
            if (byte_done_c && (state_q == ST_CMD)) begin
              cmd_d       = rx_byte_c;
              cmd_valid_d = 1'b1;
              rd_nib_d    = 1'b0;
              state_d     = rx_byte_c[CMD_READ_BIT] ? ST_READ : ST_WRITE;
            end else if (byte_done_c) begin
              rx_push_c = 1'b1;
            end
          end
        end
        ST_READ: begin
          if (qck_fall_c) begin
            oe_d     = 1'b1;
            rd_nib_d = ~rd_nib_q;
            if (!rd_nib_q) begin
              if (io_tx_valid) begin
                tx_ready_c  = 1'b1;
                load_byte_c = io_tx_payload;
              end else begin
                underrun_set_c = 1'b1;
              end
              qd_out_d = load_byte_c[BYTE_W-1:NIB_W];
              rd_lo_d  = load_byte_c[NIB_W-1:0];
            end else begin
              qd_out_d = rd_lo_q;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A full FIFO only drops the byte if nothing is popped in the same cycle.
    overrun_set_c = rx_push_c & fifo_full_c & ~io_rx_ready;
    overrun_d     = ~io_clear & (overrun_q | overrun_set_c);
    underrun_d    = ~io_clear & (underrun_q | underrun_set_c);
  end

  // Synchronisers reset low so a QSS already low at release is never seen as a select.
  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      qss_sync_q  <= '0;
      qck_sync_q  <= '0;
      qd_s1_q     <= '0;
      qd_s2_q     <= '0;
      state_q     <= ST_IDLE;
      nib_cnt_q   <= '0;
      shift_q     <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      oe_q        <= 1'b0;
      qd_out_q    <= '0;
      rd_lo_q     <= '0;
      rd_nib_q    <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      qss_sync_q  <= qss_sync_d;
      qck_sync_q  <= qck_sync_d;
      qd_s1_q     <= qd_s1_d;
      qd_s2_q     <= qd_s2_d;
      state_q     <= state_d;
      nib_cnt_q   <= nib_cnt_d;
      shift_q     <= shift_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      oe_q        <= oe_d;
      qd_out_q    <= qd_out_d;
      rd_lo_q     <= rd_lo_d;
      rd_nib_q    <= rd_nib_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
    end
  end

  qspi_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (BYTE_W)
  ) u_rx_fifo (
    .clk       (io_mainClk),
    .rst       (io_asyncReset),
    .push      (rx_push_c),
    .push_data (rx_byte_c),
    .pop       (io_rx_ready),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c),
    .head_c    (fifo_head_c)
  );

  assign io_qd_write       = qd_out_q;
  assign io_qd_writeEnable = {NIB_W{oe_q}};
  assign io_cmd_valid      = cmd_valid_q;
  assign io_cmd            = cmd_q;
  assign io_rx_valid       = ~fifo_empty_c;
  assign io_rx_payload     = fifo_head_c;
  assign io_tx_ready       = tx_ready_c;
  assign io_overrun        = overrun_q;
  assign io_underrun       = underrun_q;

endmodule
